// File: rtl/pulse_capture_multi_if.sv
// Bus bundle for pulse_capture_multi: pulse inputs, read request and read response.
// The slave modport is the capture block; the master modport is whoever drives
// the pulses and issues reads.
interface pulse_capture_multi_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] pulse_in;
    logic [SEL_W-1:0]    rd_sel;
    logic                rd_stb;
    logic [CNT_W-1:0]    rd_width;
    logic                rd_valid;
    logic                rd_timeout;
    logic [CHANNELS-1:0] new_flags;

    modport slave (
        input  pulse_in,
        input  rd_sel,
        input  rd_stb,
        output rd_width,
        output rd_valid,
        output rd_timeout,
        output new_flags
    );

    modport master (
        output pulse_in,
        output rd_sel,
        output rd_stb,
        input  rd_width,
        input  rd_valid,
        input  rd_timeout,
        input  new_flags
    );
endinterface

// File: rtl/pulse_capture_multi.sv
// Multi-channel pulse-width capture. Each asynchronous input is synchronised,
// debounced, and measured in prescaled ticks by a small per-channel FSM. Channels
// that see no rising edge for TIMEOUT ticks are flagged as lost. A strobed read
// port returns the last capture of one channel and clears its "unread" flag.
module pulse_capture_multi #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 50,
    parameter int FILTER   = 3,
    parameter int TIMEOUT  = 25000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pulse_capture_multi_if.slave  bus
);
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int FCNT_W = 4;
    // Cycles after reset release before WAIT_LOW may trust the filtered level:
    // two synchroniser stages plus the filter depth.
    localparam int SETTLE = FILTER + 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_LOW,
        ST_HIGH
    } state_t;

    logic [PRE_W-1:0]    r_presc;
    logic                w_tick;
    logic [4:0]          r_settle;
    logic                w_settled;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    logic [CHANNELS-1:0][CNT_W-1:0] w_cap;
    logic [CHANNELS-1:0]            w_valid;
    logic [CHANNELS-1:0]            w_tmo;
    logic [CHANNELS-1:0]            w_new;

    logic [CNT_W-1:0] w_rd_width;
    logic             w_rd_valid;
    logic             w_rd_tmo;

    assign w_tick    = (r_presc == PRE_W'(PRESCALE - 1));
    assign w_settled = (r_settle == 5'(SETTLE));

    // Free-running prescaler; one shared tick per PRESCALE cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Post-reset settle counter so a line already high at release is seen high
    // by the filter before any channel is allowed to leave WAIT_LOW.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (!w_settled) begin
            r_settle <= r_settle + 1'b1;
        end
    end

    // Two-flop synchroniser for all pulse inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.pulse_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic              r_filt;
        logic [FCNT_W-1:0] r_fcnt;
        state_t            r_state;
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  r_cap;
        logic [TO_W-1:0]   r_to_cnt;
        logic              r_valid;
        logic              r_tmo;
        logic              r_new;
        logic              w_rd_hit;
        logic              w_capture;
        logic              w_to_step;
        logic              w_to_last;

        assign w_rd_hit  = bus.rd_stb && (int'(bus.rd_sel) == gi);
        assign w_capture = (r_state == ST_HIGH) && !r_filt;
        assign w_to_step = w_tick && (r_to_cnt != TO_MAX);
        assign w_to_last = (r_to_cnt == TO_LAST);

        // Debounce: follow the synchronised level only after FILTER equal samples.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_filt <= 1'b0;
                r_fcnt <= '0;
            end else if (r_sync2[gi] != r_filt) begin
                if (r_fcnt == FCNT_W'(FILTER - 1)) begin
                    r_filt <= r_sync2[gi];
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end

        // Measurement FSM: width counting, capture, timeout and unread flag.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state  <= ST_WAIT_LOW;
                r_cnt    <= '0;
                r_cap    <= '0;
                r_to_cnt <= '0;
                r_valid  <= 1'b0;
                r_tmo    <= 1'b0;
                r_new    <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_LOW: begin
                        if (w_settled && !r_filt) begin
                            r_state <= ST_LOW;
                        end
                        if (w_to_step) begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (w_to_last) begin
                                r_tmo   <= 1'b1;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                    ST_LOW: begin
                        if (r_filt) begin
                            r_state  <= ST_HIGH;
                            r_cnt    <= '0;
                            r_to_cnt <= '0;
                        end else if (w_to_step) begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (w_to_last) begin
                                r_tmo   <= 1'b1;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (!r_filt) begin
                            r_cap   <= r_cnt;
                            r_valid <= 1'b1;
                            r_tmo   <= 1'b0;
                            r_new   <= 1'b1;
                            r_state <= ST_LOW;
                        end else if (w_tick && (r_cnt != CNT_MAX)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_WAIT_LOW;
                endcase
                // A read clears the unread flag unless a capture lands the same cycle.
                if (w_rd_hit && !w_capture) begin
                    r_new <= 1'b0;
                end
            end
        end

        assign w_cap[gi]   = r_cap;
        assign w_valid[gi] = r_valid;
        assign w_tmo[gi]   = r_tmo;
        assign w_new[gi]   = r_new;
    end

    assign bus.new_flags = w_new;

    // Read mux; an index outside the channel range reads as zeros.
    always_comb begin
        w_rd_width = '0;
        w_rd_valid = 1'b0;
        w_rd_tmo   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.rd_sel) == i) begin
                w_rd_width = w_cap[i];
                w_rd_valid = w_valid[i];
                w_rd_tmo   = w_tmo[i];
            end
        end
    end

    // Read response registers; they hold their value between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_width   <= '0;
            bus.rd_valid   <= 1'b0;
            bus.rd_timeout <= 1'b0;
        end else if (bus.rd_stb) begin
            bus.rd_width   <= w_rd_width;
            bus.rd_valid   <= w_rd_valid;
            bus.rd_timeout <= w_rd_tmo;
        end
    end
endmodule

// File: doc/pulse_capture_multi.md
PULSE_CAPTURE_MULTI -- requirements
Module: pulse_capture_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of independent pulse inputs (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width counter and captured-width register width in ticks (8..24).
REQ-003 SHALL have parameter PRESCALE, default 50, clk cycles per tick (1 us at 50 MHz), range 1..65535.
REQ-004 SHALL have parameter FILTER, default 3, consecutive stable synchronised samples required to accept a level change (1..15).
REQ-005 SHALL have parameter TIMEOUT, default 25000, ticks without a rising edge before a channel is declared lost.
REQ-006 SHALL have clk  input  1  system clock; every register clocks on its rising edge.
REQ-007 SHALL have rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-008 SHALL have pulse_in  input  CHANNELS  asynchronous pulse inputs (RC receiver, encoder PPR).
REQ-009 SHALL have rd_sel  input  max(1,clog2(CHANNELS))  channel index for read.
REQ-010 SHALL have rd_stb  input  1  one-cycle read request.
REQ-011 SHALL have rd_width  output  CNT_W  last captured high width of selected channel, in ticks.
REQ-012 SHALL have rd_valid  output  1  selected channel holds at least one capture and is not timed out.
REQ-013 SHALL have rd_timeout  output  1  selected channel timed out.
REQ-014 SHALL have new_flags  output  CHANNELS  per-channel "unread capture" flags.

Function
REQ-015 SHALL pass each pulse_in bit through a 2-flop synchroniser, then a per-channel filter whose output changes only after FILTER consecutive equal synchronised samples differing from it.
REQ-016 SHALL generate one shared tick pulse every PRESCALE clk cycles from a free-running prescaler; PRESCALE=1 means tick every cycle.
REQ-017 SHALL run a per-channel FSM with states WAIT_LOW, LOW, HIGH; reset state WAIT_LOW.
REQ-018 SHALL move WAIT_LOW->LOW when filtered level is 0, so a pulse already high at reset release is discarded.
REQ-019 SHALL move LOW->HIGH on filtered rising edge, clearing the width counter to 0 in the same cycle.
REQ-020 SHALL increment the width counter by 1 per tick while in HIGH, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL, on filtered falling edge in HIGH, latch the counter into the channel capture register, set valid, clear timeout, set new_flags[ch], go to LOW, all in one cycle.
REQ-022 SHALL count ticks in a per-channel timeout counter in WAIT_LOW and LOW, clear it on each rising edge, and on reaching TIMEOUT set timeout, clear valid, keep the capture register, hold the counter (no wrap).
REQ-023 SHALL not time out in HIGH; a stuck-high line shows as saturated width on its eventual falling edge.
REQ-024 SHALL latency: pulse_in edge to filtered edge = 2+FILTER clk cycles; falling filtered edge to new_flags set = 1 cycle.
REQ-025 SHALL, on rd_stb, register rd_width/rd_valid/rd_timeout of channel rd_sel on the next clk edge and clear new_flags[rd_sel] the same edge; outputs hold between strobes.
REQ-026 SHALL, when rd_stb and a capture on the same channel coincide, present the pre-capture value and leave new_flags set (capture wins).
REQ-027 SHALL treat rd_sel >= CHANNELS as a read of zeros, clearing no flag.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, clear all outputs to 0, all counters, capture registers, valid/timeout/new flags, filter outputs to 0, prescaler to 0, FSMs to WAIT_LOW.
REQ-029 SHALL, on reset asserted mid-pulse, discard the in-progress measurement; the first capture after release requires a full low-high-low sequence.

Verification
REQ-030 SHALL cover: PRESCALE=50, 1500 us pulse on ch2 -> new_flags[2]=1 within 5 clk of falling edge; rd_sel=2, rd_stb -> rd_width=1500 (+/-1), rd_valid=1, new_flags[2]=0.
REQ-031 SHALL cover: FILTER=3, 2-cycle glitch high on ch0 -> no state change, new_flags=0; 3-cycle-stable pulse is accepted.
REQ-032 SHALL cover: CNT_W=8, 300-tick pulse -> rd_width=255.
REQ-033 SHALL cover: TIMEOUT=100, no edges on ch5 for 100 ticks after a capture -> rd_timeout=1, rd_valid=0, rd_width unchanged; next pulse restores rd_valid=1, rd_timeout=0.
REQ-034 SHALL cover: pulse_in[1] high across rst_n release, falls, then 1000-tick pulse -> only one capture, value 1000.
REQ-035 SHALL cover: rd_stb on ch3 in the same cycle its capture completes -> old rd_width returned, new_flags[3] stays 1; next read returns new width.
